fetch_ctrl: RTL and testbench

Fetch sequencer between the PC/instruction-memory datapath and decode. It owns the fetch PC, issues one read per cycle to a synchronous (1-cycle latency) instruction memory, and buffers returned words in a two-entry output/skid store so decode can apply backpressure without losing fetches. It also applies taken-branch/jump redirects from execute and squashes wrong-path words.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 25 ++
 rtl/fetch_slot_buf.sv | 94 +++++++++
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and occupancy encoding for the fetch sequencer.
package fetch_pkg;

   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Number of valid entries in the output/skid store.
   typedef enum logic [1:0] {
      OccEmpty = 2'd0,
      OccOne   = 2'd1,
      OccTwo   = 2'd2
   } occ_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch sequencer bus: instruction-memory port, execute redirect and decode handshake.
interface fetch_ctrl_if;

   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic        misalign_trap;

   modport master (
      output imem_en, imem_addr, instr, pc_out, instr_valid, misalign_trap,
      input  imem_rdata, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_en, imem_addr, instr, pc_out, instr_valid, misalign_trap,
      output imem_rdata, redirect_valid, redirect_pc, instr_ready
   );

endinterface

// File: rtl/fetch_slot_buf.sv
// Two-entry output/skid store: routes memory responses, shifts skid forward on accept, flushes.
module fetch_slot_buf
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_i,
   input  logic        push_i,
   input  logic [31:0] push_instr_i,
   input  logic [31:0] push_pc_i,
   input  logic        pop_i,
   output logic        out_valid_o,
   output logic        sk_valid_o,
   output logic [31:0] out_instr_o,
   output logic [31:0] out_pc_o
);

   occ_e        state_q, state_d;
   logic [31:0] out_instr_q, out_instr_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] sk_instr_q, sk_instr_d;
   logic [31:0] sk_pc_q, sk_pc_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= OccEmpty;
         out_instr_q <= INSTR_NOP;
         out_pc_q    <= RESET_PC;
         sk_instr_q  <= INSTR_NOP;
         sk_pc_q     <= RESET_PC;
      end else begin
         state_q     <= state_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
         sk_instr_q  <= sk_instr_d;
         sk_pc_q     <= sk_pc_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;
      sk_instr_d  = sk_instr_q;
      sk_pc_d     = sk_pc_q;
      if (flush_i) begin
         state_d = OccEmpty;
      end else begin
         unique case (state_q)
            OccEmpty: begin
               if (push_i) begin
                  out_instr_d = push_instr_i;
                  out_pc_d    = push_pc_i;
                  state_d     = OccOne;
               end
            end
            OccOne: begin
               if (push_i && pop_i) begin
                  out_instr_d = push_instr_i;
                  out_pc_d    = push_pc_i;
               end else if (push_i) begin
                  sk_instr_d = push_instr_i;
                  sk_pc_d    = push_pc_i;
                  state_d    = OccTwo;
               end else if (pop_i) begin
                  state_d = OccEmpty;
               end
            end
            OccTwo: begin
               // Issue is blocked while full, so a push here always pairs with a pop.
               if (pop_i) begin
                  out_instr_d = sk_instr_q;
                  out_pc_d    = sk_pc_q;
                  if (push_i) begin
                     sk_instr_d = push_instr_i;
                     sk_pc_d    = push_pc_i;
                  end else begin
                     state_d = OccOne;
                  end
               end
            end
            default: state_d = OccEmpty;
         endcase
      end
   end

   assign out_valid_o = (state_q != OccEmpty);
   assign sk_valid_o  = (state_q == OccTwo);
   assign out_instr_o = out_instr_q;
   assign out_pc_o    = out_pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns fetch PC, issues imem reads, applies redirects.
// Define FETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of aligning them.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input logic          clk,
   input logic          reset,
   fetch_ctrl_if.master bus
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        req_q, req_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        out_valid, sk_valid;
   logic        redir, misaligned, trap_q;
   logic        fire, issue;
   logic [31:0] redir_tgt;
   logic [1:0]  count_next;

   assign redir     = bus.redirect_valid & ~reset;
   assign redir_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic trap_d;

   assign misaligned = redir & (bus.redirect_pc[1:0] != 2'b00);

   always_comb begin
      trap_d = trap_q;
      if (misaligned) begin
         trap_d = 1'b1;
      end else if (redir) begin
         trap_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         trap_q <= 1'b0;
      end else begin
         trap_q <= trap_d;
      end
   end
`else
   assign misaligned = 1'b0;
   assign trap_q     = 1'b0;
`endif

   // Redirect masks the offered word combinationally so decode never takes a wrong-path word.
   assign bus.instr_valid   = out_valid & ~redir;
   assign bus.misalign_trap = trap_q;
   assign fire              = bus.instr_valid & bus.instr_ready;
   assign count_next        = {1'b0, out_valid} + {1'b0, sk_valid} + {1'b0, req_q} - {1'b0, fire};
   assign issue             = ~reset & ~trap_q & ~redir & (count_next < 2'd2);

   always_comb begin
      bus.imem_en   = issue;
      bus.imem_addr = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      if (redir && !misaligned) begin
         bus.imem_en   = 1'b1;
         bus.imem_addr = redir_tgt;
         fetch_pc_d    = redir_tgt + 32'd4;
         req_pc_d      = redir_tgt;
      end else if (issue) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         req_pc_d   = fetch_pc_q;
      end
   end

   assign req_d = bus.imem_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         req_pc_q   <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         req_pc_q   <= req_pc_d;
      end
   end

   fetch_slot_buf #(
      .RESET_PC(RESET_PC)
   ) u_slot_buf (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (redir),
      .push_i      (req_q),
      .push_instr_i(bus.imem_rdata),
      .push_pc_i   (req_pc_q),
      .pop_i       (fire),
      .out_valid_o (out_valid),
      .sk_valid_o  (sk_valid),
      .out_instr_o (bus.instr),
      .out_pc_o    (bus.pc_out)
   );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: scripted scenarios then random ready/redirect traffic
// against a counter/queue-level reference model.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b0;

   fetch_ctrl_if bus ();

   fetch_ctrl #(
      .RESET_PC(RST_PC)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Memory word is a fixed function of its address so every word is traceable to its PC.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
   end

   int          n_checks;
   int          n_errors;
   int          buffered;
   int          inflight;
   logic        trapped;
   logic [31:0] iss_pc;
   logic [31:0] acc_pc;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: words landed-but-unaccepted, one request in flight, next fetch and next accepted PC.
   task automatic model_cycle();
      logic        exp_valid;
      logic        fire_e;
      logic        en_e;
      int          room;
      logic [31:0] tgt;
      if (reset) begin
         check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
         check_eq("rst_en", 32'(bus.imem_en), 32'd0);
         check_eq("rst_addr", bus.imem_addr, RST_PC);
         check_eq("rst_instr", bus.instr, INSTR_NOP);
         check_eq("rst_pc", bus.pc_out, RST_PC);
         check_eq("rst_trap", 32'(bus.misalign_trap), 32'd0);
         buffered = 0;
         inflight = 0;
         trapped  = 1'b0;
         iss_pc   = RST_PC;
         acc_pc   = RST_PC;
         return;
      end
      check_eq("trap", 32'(bus.misalign_trap), 32'(trapped));
      exp_valid = (buffered > 0) && !bus.redirect_valid;
      check_eq("valid", 32'(bus.instr_valid), 32'(exp_valid));
      if (exp_valid) begin
         check_eq("pc_out", bus.pc_out, acc_pc);
         check_eq("instr", bus.instr, mem_word(acc_pc));
      end
      fire_e = exp_valid && bus.instr_ready;
      if (fire_e) acc_pc = acc_pc + 32'd4;
      if (bus.redirect_valid) begin
         tgt = bus.redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
         if (bus.redirect_pc[1:0] != 2'b00) begin
            check_eq("trap_en", 32'(bus.imem_en), 32'd0);
            buffered = 0;
            inflight = 0;
            trapped  = 1'b1;
            return;
         end
`endif
         check_eq("redir_en", 32'(bus.imem_en), 32'd1);
         check_eq("redir_addr", bus.imem_addr, tgt);
         buffered = 0;
         inflight = 1;
         trapped  = 1'b0;
         iss_pc   = tgt + 32'd4;
         acc_pc   = tgt;
      end else begin
         room = buffered + inflight - (fire_e ? 1 : 0);
         en_e = !trapped && (room < 2);
         check_eq("imem_en", 32'(bus.imem_en), 32'(en_e));
         if (!trapped) check_eq("imem_addr", bus.imem_addr, iss_pc);
         if (en_e) iss_pc = iss_pc + 32'd4;
         buffered = room;
         inflight = en_e ? 1 : 0;
      end
   endtask

   task automatic step(input logic rst_v, input logic rdy, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      reset              = rst_v;
      bus.instr_ready    = rdy;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      @(negedge clk);
      model_cycle();
   endtask

   initial begin
      int first_valid;
      n_checks = 0;
      n_errors = 0;
      buffered = 0;
      inflight = 0;
      trapped  = 1'b0;
      iss_pc   = RST_PC;
      acc_pc   = RST_PC;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      #1 reset = 1'b1;
      #1 model_cycle();

      // Redirect while held in reset must be ignored.
      repeat (2) step(1'b1, 1'b1, 1'b1, 32'h0000_0040);

      first_valid = -1;
      for (int c = 0; c < 20; c++) begin
         step(1'b0, !(c >= 5 && c <= 9), 1'b0, 32'h0);
         if (bus.instr_valid && first_valid < 0) first_valid = c;
      end
      check_eq("first_valid", 32'(first_valid), 32'd2);

      // Fill both slots, then redirect.
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         if (k == 0) check_eq("redir_gap", 32'(bus.instr_valid), 32'd0);
         if (k == 1) check_eq("redir_tgt", bus.pc_out, 32'h0000_0100);
         if (k == 2) check_eq("redir_tgt4", bus.pc_out, 32'h0000_0104);
      end

      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      for (int k = 0; k < 6; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         if (k == 3) check_eq("wrap_pc", bus.pc_out, 32'h0000_0000);
      end

      step(1'b0, 1'b1, 1'b1, 32'h0000_0102);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
         if (k == 1) check_eq("trap_set", 32'(bus.misalign_trap), 32'd1);
         if (k == 1) check_eq("trap_halt", 32'(bus.imem_en), 32'd0);
`else
         if (k == 1) check_eq("align_pc", bus.pc_out, 32'h0000_0100);
`endif
      end
      step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
      for (int k = 0; k < 4; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         if (k == 0) check_eq("trap_clr", 32'(bus.misalign_trap), 32'd0);
         if (k == 1) check_eq("resume_pc", bus.pc_out, 32'h0000_0200);
      end

      // Reset mid-stream with skid full, alongside a redirect.
      repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b1, 32'h0000_0300);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, 1'b0, 32'h0);
         if (k == 2) check_eq("restart_pc", bus.pc_out, RST_PC);
      end

      for (int i = 0; i < 600; i++) begin
         logic        rv;
         logic        rdy;
         logic [31:0] rpc;
         rv  = ($urandom_range(0, 11) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         rpc = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
         step(1'b0, rdy, rv, rpc);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
